branch_predict_unit: RTL and testbench
======================================

Name: branch_predict_unit

Overview:
- Parametrised successor to the execute-stage branch comparator.
- Resolves conditional branches (beq/bne/blt/bge/bltu/bgeu) at configurable XLEN.
- Adds a direct-mapped branch history table (BHT) of saturating counters. Fetch reads it for a taken/not-taken prediction; execute trains it on resolution.
- Flags mispredictions to the hazard/flush logic and keeps a saturating mispredict counter for performance monitoring.

Parameters:
- XLEN, 32: operand and PC width.
- BHT_ENTRIES, 64: table depth; power of two, minimum 2.
- CTR_WIDTH, 2: saturating counter width, 1 to 4.
- PC_LSB, 2: lowest PC bit used in the index.
- INIT_CTR, 1: reset value of every counter (1 = weakly not-taken for CTR_WIDTH=2).
- PERF_WIDTH, 32: mispredict counter width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- pcF  in  XLEN  fetch PC used for lookup.
- predTakenF  out  1  prediction for pcF (combinational).
- validE  in  1  execute stage holds a valid, non-flushed instruction.
- isBranchE  in  1  instruction is a conditional branch.
- pcE  in  XLEN  PC of the execute-stage instruction.
- SrcAE, SrcBE  in  XLEN  comparison operands.
- funct3E  in  3  branch condition.
- predTakenE  in  1  prediction piped from fetch with this instruction.
- branchTakenE  out  1  resolved outcome.
- mispredictE  out  1  outcome differs from the prediction.
- illegalCondE  out  1  funct3 is 010 or 011 on a valid branch.
- mispredictCount  out  PERF_WIDTH  saturating total of mispredictions.

Behaviour:
- Index: IDX_W = log2(BHT_ENTRIES).
  - Fetch index = pcF[PC_LSB +: IDX_W].
  - Execute index = pcE[PC_LSB +: IDX_W].
  - No tag; aliasing is accepted.
- Prediction: predTakenF = MSB of counter[fetch index]. Purely combinational, zero latency.
- Resolution (combinational):
  - eq = A==B; lt = signed A<B; ltu = unsigned A<B.
  - 000→eq, 001→!eq, 100→lt, 101→!lt, 110→ltu, 111→!ltu.
  - 010/011 → branchTakenE=0 and illegalCondE = validE & isBranchE.
- Gating:
  - branchTakenE is forced 0 when !(validE & isBranchE).
  - mispredictE = validE & isBranchE & !illegalCondE & (branchTakenE != predTakenE).
- Training, on the rising edge when validE & isBranchE & !illegalCondE:
  - taken: counter increments, saturating at 2^CTR_WIDTH-1.
  - not taken: counter decrements, saturating at 0.
  - All other entries hold.
- Same-cycle read/write of one index: predTakenF reflects the pre-update value. No bypass.
- Perf counter: increments by 1 on every cycle with mispredictE=1. It saturates at all-ones and does not wrap.
- Reset (asynchronous, any time, including mid-training):
  - Every counter is set to INIT_CTR and mispredictCount to 0.
  - Combinational outputs follow the reset table immediately: predTakenF = MSB(INIT_CTR), i.e. 0 at defaults.
  - branchTakenE, mispredictE and illegalCondE depend only on inputs.
- No stall input: the pipeline must deassert validE for stalled or flushed execute slots so no double training occurs.

Decomposition:
- Shared package branch_pkg:
  - funct3 localparams BR_BEQ, BR_BNE, BR_BLT, BR_BGE, BR_BLTU, BR_BGEU.
  - A bht_idx helper function.
- Sub-module branch_cmp (combinational): parametrised XLEN condition evaluator producing taken and illegal.
- The top holds the counter array, training and perf logic.

Test Plan:
- Reset then pcF=0x100 → predTakenF=0. Apply beq with A=B=5 at pcE=0x100, predTakenE=0 → branchTakenE=1, mispredictE=1. Next cycle predTakenF=1 (counter 01→10), mispredictCount=1.
- Four consecutive taken bne (A=1,B=2) at pcE=0x40 → counter saturates at 3. Then one not-taken → counter 2, predTakenF still 1.
- Signed vs unsigned: A=0xFFFFFFFF, B=1 → blt taken, bltu not taken, bge not taken, bgeu taken.
- funct3=010, validE=1, isBranchE=1 → illegalCondE=1, branchTakenE=0, mispredictE=0, no table or counter change.
- pcF=pcE=0x200 with a training taken branch → predTakenF shows the old value that cycle and the new value the next.
- Assert rst_n low mid-sequence after training index 5 to 3 → the entry immediately reads INIT_CTR and mispredictCount=0. Also check validE=0 with mismatching operands produces no update.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolution / prediction unit:
// branch condition encodings and the BHT index extraction helper.
package branch_pkg;

    localparam logic [2:0] BR_BEQ  = 3'b000;
    localparam logic [2:0] BR_BNE  = 3'b001;
    localparam logic [2:0] BR_BLT  = 3'b100;
    localparam logic [2:0] BR_BGE  = 3'b101;
    localparam logic [2:0] BR_BLTU = 3'b110;
    localparam logic [2:0] BR_BGEU = 3'b111;

    // Table index is a plain bit-slice of the PC; callers truncate to their index width.
    function automatic logic [31:0] bht_idx(input logic [63:0] pc,
                                            input int unsigned pc_lsb,
                                            input int unsigned idx_w);
        logic [63:0] shifted;
        shifted = pc >> pc_lsb;
        return shifted[31:0] & ((32'd1 << idx_w) - 32'd1);
    endfunction

endpackage

// File: rtl/branch_cmp.sv
// Combinational branch condition evaluator. Outputs are ungated; the
// caller qualifies them with the valid/branch strobes.
module branch_cmp
    import branch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [2:0]      funct3,
    output logic            taken,
    output logic            illegal
);

    logic signed [XLEN-1:0] a_s;
    logic signed [XLEN-1:0] b_s;
    logic                   eq;
    logic                   lt;
    logic                   ltu;

    assign a_s = a;
    assign b_s = b;
    assign eq  = (a == b);
    assign lt  = (a_s < b_s);
    assign ltu = (a < b);

    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (funct3)
            BR_BEQ:  taken = eq;
            BR_BNE:  taken = !eq;
            BR_BLT:  taken = lt;
            BR_BGE:  taken = !lt;
            BR_BLTU: taken = ltu;
            BR_BGEU: taken = !ltu;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_predict_unit.sv
// Execute-stage branch resolution with a direct-mapped table of saturating
// counters for fetch prediction and a saturating mispredict counter.
module branch_predict_unit
    import branch_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int CTR_WIDTH   = 2,
    parameter int PC_LSB      = 2,
    parameter int INIT_CTR    = 1,
    parameter int PERF_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [XLEN-1:0]       pcF,
    output logic                  predTakenF,
    input  logic                  validE,
    input  logic                  isBranchE,
    input  logic [XLEN-1:0]       pcE,
    input  logic [XLEN-1:0]       SrcAE,
    input  logic [XLEN-1:0]       SrcBE,
    input  logic [2:0]            funct3E,
    input  logic                  predTakenE,
    output logic                  branchTakenE,
    output logic                  mispredictE,
    output logic                  illegalCondE,
    output logic [PERF_WIDTH-1:0] mispredictCount
);

    localparam int                   IDX_W  = $clog2(BHT_ENTRIES);
    localparam logic [CTR_WIDTH-1:0] CTR_MAX = '1;
    localparam logic [CTR_WIDTH-1:0] INIT_V  = CTR_WIDTH'(INIT_CTR);

    logic [CTR_WIDTH-1:0]  ctr_q [BHT_ENTRIES];
    logic [CTR_WIDTH-1:0]  ctr_d [BHT_ENTRIES];
    logic [PERF_WIDTH-1:0] perf_q;
    logic [PERF_WIDTH-1:0] perf_d;

    logic [IDX_W-1:0] idx_f;
    logic [IDX_W-1:0] idx_e;
    logic             cmp_taken;
    logic             cmp_illegal;
    logic             br_valid;
    logic             train;

    assign idx_f = IDX_W'(bht_idx(64'(pcF), PC_LSB, IDX_W));
    assign idx_e = IDX_W'(bht_idx(64'(pcE), PC_LSB, IDX_W));

    branch_cmp #(.XLEN(XLEN)) u_cmp (
        .a       (SrcAE),
        .b       (SrcBE),
        .funct3  (funct3E),
        .taken   (cmp_taken),
        .illegal (cmp_illegal)
    );

    assign br_valid     = validE & isBranchE;
    assign illegalCondE = br_valid & cmp_illegal;
    assign branchTakenE = br_valid & cmp_taken;
    assign train        = br_valid & !cmp_illegal;
    assign mispredictE  = train & (branchTakenE != predTakenE);

    // Read is from the registered table, so a same-cycle update is not bypassed.
    assign predTakenF      = ctr_q[idx_f][CTR_WIDTH-1];
    assign mispredictCount = perf_q;

    always_comb begin
        ctr_d = ctr_q;
        if (train) begin
            if (branchTakenE) begin
                if (ctr_q[idx_e] != CTR_MAX) begin
                    ctr_d[idx_e] = ctr_q[idx_e] + CTR_WIDTH'(1);
                end
            end else if (ctr_q[idx_e] != '0) begin
                ctr_d[idx_e] = ctr_q[idx_e] - CTR_WIDTH'(1);
            end
        end
    end

    always_comb begin
        perf_d = perf_q;
        if (mispredictE && (perf_q != '1)) begin
            perf_d = perf_q + PERF_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                ctr_q[i] <= INIT_V;
            end
            perf_q <= '0;
        end else begin
            ctr_q  <= ctr_d;
            perf_q <= perf_d;
        end
    end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench: directed scenarios with literal expectations followed by
// randomized traffic compared every cycle against a behavioural table model.
module tb_branch_predict_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] pcF;
    logic        predTakenF;
    logic        validE;
    logic        isBranchE;
    logic [31:0] pcE;
    logic [31:0] SrcAE;
    logic [31:0] SrcBE;
    logic [2:0]  funct3E;
    logic        predTakenE;
    logic        branchTakenE;
    logic        mispredictE;
    logic        illegalCondE;
    logic [31:0] mispredictCount;

    int checks = 0;
    int errors = 0;

    branch_predict_unit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pcF             (pcF),
        .predTakenF      (predTakenF),
        .validE          (validE),
        .isBranchE       (isBranchE),
        .pcE             (pcE),
        .SrcAE           (SrcAE),
        .SrcBE           (SrcBE),
        .funct3E         (funct3E),
        .predTakenE      (predTakenE),
        .branchTakenE    (branchTakenE),
        .mispredictE     (mispredictE),
        .illegalCondE    (illegalCondE),
        .mispredictCount (mispredictCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: 64 counters in 0..3, predicted taken when >= 2.
    int          mctr [64];
    logic [31:0] mperf;
    logic        e_legal, e_cond, e_taken, e_ill, e_mis, e_pred;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % 64);
    endfunction

    always_comb begin
        e_legal = 1'b1;
        e_cond  = 1'b0;
        case (funct3E)
            3'd0: e_cond = (SrcAE == SrcBE);
            3'd1: e_cond = (SrcAE != SrcBE);
            3'd4: e_cond = ($signed(SrcAE) < $signed(SrcBE));
            3'd5: e_cond = ($signed(SrcAE) >= $signed(SrcBE));
            3'd6: e_cond = (SrcAE < SrcBE);
            3'd7: e_cond = (SrcAE >= SrcBE);
            default: e_legal = 1'b0;
        endcase
        e_taken = validE && isBranchE && e_legal && e_cond;
        e_ill   = validE && isBranchE && !e_legal;
        e_mis   = validE && isBranchE && e_legal && (e_cond != predTakenE);
        e_pred  = (mctr[idx_of(pcF)] >= 2);
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) mctr[i] <= 1;
            mperf <= 32'd0;
        end else begin
            if (validE && isBranchE && e_legal) begin
                if (e_cond) mctr[idx_of(pcE)] <= (mctr[idx_of(pcE)] == 3) ? 3 : mctr[idx_of(pcE)] + 1;
                else        mctr[idx_of(pcE)] <= (mctr[idx_of(pcE)] == 0) ? 0 : mctr[idx_of(pcE)] - 1;
            end
            if (e_mis && mperf != 32'hFFFF_FFFF) mperf <= mperf + 32'd1;
        end
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison, 2 time units after inputs change on the falling edge.
    always @(negedge clk) begin
        #2;
        check("m_predTakenF",   64'(predTakenF),      64'(e_pred));
        check("m_branchTakenE", 64'(branchTakenE),    64'(e_taken));
        check("m_mispredictE",  64'(mispredictE),     64'(e_mis));
        check("m_illegalCondE", 64'(illegalCondE),    64'(e_ill));
        check("m_count",        64'(mispredictCount), 64'(mperf));
    end

    task automatic br(input logic v, input logic b, input logic [31:0] pc,
                      input logic [31:0] a, input logic [31:0] bb,
                      input logic [2:0] f3, input logic pt);
        @(negedge clk);
        validE = v; isBranchE = b; pcE = pc;
        SrcAE = a; SrcBE = bb; funct3E = f3; predTakenE = pt;
        #3;
    endtask

    task automatic idle();
        br(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 3'd0, 1'b0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #3 rst_n = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; pcF = 32'h100;
        validE = 0; isBranchE = 0; pcE = 0; SrcAE = 0; SrcBE = 0; funct3E = 0; predTakenE = 0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;

        // Cold beq at 0x100 mispredicts and moves counter 1 -> 2.
        br(1, 1, 32'h100, 32'd5, 32'd5, 3'b000, 0);
        check("t1_pred_before", 64'(predTakenF), 64'd0);
        check("t1_taken",       64'(branchTakenE), 64'd1);
        check("t1_mis",         64'(mispredictE), 64'd1);
        idle();
        check("t1_pred_after",  64'(predTakenF), 64'd1);
        check("t1_count",       64'(mispredictCount), 64'd1);

        // Saturate entry for 0x40, then one not-taken leaves it at 2.
        pcF = 32'h40;
        repeat (4) br(1, 1, 32'h40, 32'd1, 32'd2, 3'b001, 1);
        idle();
        check("t2_pred_sat", 64'(predTakenF), 64'd1);
        br(1, 1, 32'h40, 32'd2, 32'd2, 3'b001, 1);
        check("t2_nt_mis", 64'(mispredictE), 64'd1);
        idle();
        check("t2_pred_2",  64'(predTakenF), 64'd1);
        check("t2_count",   64'(mispredictCount), 64'd2);

        // Signed versus unsigned ordering of 0xFFFFFFFF against 1.
        br(1, 1, 32'h0, 32'hFFFF_FFFF, 32'd1, 3'b100, 0);
        check("t3_blt",  64'(branchTakenE), 64'd1);
        br(1, 1, 32'h0, 32'hFFFF_FFFF, 32'd1, 3'b110, 0);
        check("t3_bltu", 64'(branchTakenE), 64'd0);
        br(1, 1, 32'h0, 32'hFFFF_FFFF, 32'd1, 3'b101, 0);
        check("t3_bge",  64'(branchTakenE), 64'd0);
        br(1, 1, 32'h0, 32'hFFFF_FFFF, 32'd1, 3'b111, 0);
        check("t3_bgeu", 64'(branchTakenE), 64'd1);
        idle();
        check("t3_count", 64'(mispredictCount), 64'd4);

        // Illegal condition: flagged, no outcome, no training, no count.
        pcF = 32'h80;
        br(1, 1, 32'h80, 32'd7, 32'd7, 3'b010, 1);
        check("t4_illegal", 64'(illegalCondE), 64'd1);
        check("t4_taken",   64'(branchTakenE), 64'd0);
        check("t4_mis",     64'(mispredictE), 64'd0);
        br(1, 1, 32'h80, 32'd7, 32'd8, 3'b011, 1);
        idle();
        check("t4_count", 64'(mispredictCount), 64'd4);
        br(1, 1, 32'h80, 32'd7, 32'd7, 3'b000, 1);
        idle();
        check("t4_pred_untouched", 64'(predTakenF), 64'd1);

        // Same-cycle lookup and training of one index: no bypass.
        pulse_reset();
        pcF = 32'h200;
        br(1, 1, 32'h200, 32'd3, 32'd3, 3'b000, 0);
        check("t5_pred_old", 64'(predTakenF), 64'd0);
        idle();
        check("t5_pred_new", 64'(predTakenF), 64'd1);

        // Train index 5 to 3, confirm invalid slots do not train, then reset mid-cycle.
        pcF = 32'h14;
        br(1, 1, 32'h14, 32'd9, 32'd9, 3'b000, 1);
        br(1, 1, 32'h14, 32'd9, 32'd9, 3'b000, 1);
        br(0, 1, 32'h14, 32'd1, 32'd2, 3'b000, 1);
        check("t6_inv_taken", 64'(branchTakenE), 64'd0);
        check("t6_inv_mis",   64'(mispredictE), 64'd0);
        br(0, 1, 32'h14, 32'd1, 32'd2, 3'b000, 1);
        idle();
        check("t6_pred_held", 64'(predTakenF), 64'd1);
        check("t6_count",     64'(mispredictCount), 64'd1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_pred",  64'(predTakenF), 64'd0);
        check("t6_rst_count", 64'(mispredictCount), 64'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;

        // Randomized traffic with heavy aliasing and occasional async resets.
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] pc_r, a_r, b_r;
            pc_r = {$urandom_range(0, 3), 22'd0, 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3))};
            case ($urandom_range(0, 3))
                0: a_r = 32'h8000_0000;
                1: a_r = 32'hFFFF_FFFF;
                default: a_r = $urandom;
            endcase
            case ($urandom_range(0, 3))
                0: b_r = a_r;
                1: b_r = $urandom_range(0, 2);
                default: b_r = $urandom;
            endcase
            br($urandom_range(0, 7) != 0, $urandom_range(0, 5) != 0, pc_r, a_r, b_r,
               3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            pcF = ($urandom_range(0, 1) != 0) ? pc_r : {$urandom_range(0, 255), 8'($urandom)};
            if ($urandom_range(0, 299) == 0) begin
                rst_n = 1'b0;
                @(negedge clk);
                #1 rst_n = 1'b1;
            end
        end

        idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
